pc_redirect_ctrl: RTL and testbench

//  Sequences every control-flow redirect of the pipelined 16-bit CPU. Arbitrates between
//  ID-stage direct jumps (JMP/JAL) and EX-stage resolved branches / register jumps, forms the

---
 rtl/pc_redirect_ctrl.sv | 133 +++++++++++++
 tb/tb_pc_redirect_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/pc_redirect_ctrl.sv
// Control-flow redirect sequencer: arbitrates ID jumps vs EX branches/register
// jumps, forms the target PC, and hands a valid/ready redirect to fetch.
module pc_redirect_ctrl #(
    parameter int WORD_SIZE = 16,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 id_valid,
    input  logic [3:0]           id_opcode,
    input  logic [WORD_SIZE-1:0] id_pc,
    input  logic [WORD_SIZE-1:0] id_imm,
    input  logic                 ex_valid,
    input  logic [3:0]           ex_opcode,
    input  logic [WORD_SIZE-1:0] ex_pc,
    input  logic [WORD_SIZE-1:0] ex_imm,
    input  logic                 ex_br_taken,
    input  logic                 ex_jr_req,
    input  logic [WORD_SIZE-1:0] ex_jr_target,
    input  logic                 redir_ready,
    output logic                 redir_valid,
    output logic [WORD_SIZE-1:0] redir_pc,
    output logic                 flush_if,
    output logic                 flush_id,
    output logic                 stall_fe,
    output logic [CNT_WIDTH-1:0] redir_cnt
);

    localparam logic [3:0] OP_BNE = 4'd0;
    localparam logic [3:0] OP_BEQ = 4'd1;
    localparam logic [3:0] OP_BGZ = 4'd2;
    localparam logic [3:0] OP_BLZ = 4'd3;
    localparam logic [3:0] OP_JMP = 4'd9;
    localparam logic [3:0] OP_JAL = 4'd10;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_PEND = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [WORD_SIZE-1:0]   r_pc;
    logic                   r_flush_if;
    logic                   r_flush_id;
    logic [CNT_WIDTH-1:0]   r_cnt;

    logic                   w_ex_is_br;
    logic                   w_ex_req;
    logic                   w_id_req;
    logic [WORD_SIZE-1:0]   w_ex_tgt;
    logic [WORD_SIZE-1:0]   w_id_tgt;
    logic                   w_take;
    logic                   w_accept;

    assign w_ex_is_br = (ex_opcode == OP_BNE) || (ex_opcode == OP_BEQ) ||
                        (ex_opcode == OP_BGZ) || (ex_opcode == OP_BLZ);
    assign w_ex_req   = ex_valid && ((w_ex_is_br && ex_br_taken) || ex_jr_req);
    assign w_id_req   = id_valid && ((id_opcode == OP_JMP) || (id_opcode == OP_JAL));

    // Adder drops the carry, so branch targets wrap modulo 2^WORD_SIZE.
    assign w_ex_tgt = ex_jr_req ? ex_jr_target : (ex_pc + ex_imm);
    assign w_id_tgt = {id_pc[WORD_SIZE-1:12], id_imm[11:0]};

    assign w_take   = (r_state == S_IDLE) && (w_ex_req || w_id_req);
    assign w_accept = (r_state == S_PEND) && redir_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: if (w_take)      w_state_nxt = S_PEND;
            S_PEND: if (redir_ready) w_state_nxt = S_IDLE;
            default:                 w_state_nxt = S_IDLE;
        endcase
    end

    // Target and flush pulses are captured only on the IDLE->PEND edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pc       <= '0;
            r_flush_if <= 1'b0;
            r_flush_id <= 1'b0;
        end else if (w_take) begin
            r_pc       <= w_ex_req ? w_ex_tgt : w_id_tgt;
            r_flush_if <= 1'b1;
            r_flush_id <= w_ex_req;
        end else begin
            r_flush_if <= 1'b0;
            r_flush_id <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            r_cnt <= r_cnt + CNT_WIDTH'(1);
        end
    end

    always_comb begin
        redir_valid = 1'b0;
        stall_fe    = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                redir_valid = 1'b0;
                stall_fe    = 1'b0;
            end
            S_PEND: begin
                redir_valid = 1'b1;
                stall_fe    = 1'b1;
            end
            default: begin
                redir_valid = 1'b0;
                stall_fe    = 1'b0;
            end
        endcase
    end

    assign redir_pc  = r_pc;
    assign flush_if  = r_flush_if;
    assign flush_id  = r_flush_id;
    assign redir_cnt = r_cnt;

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Directed bench for pc_redirect_ctrl with an in-bench redirect model.
module tb_pc_redirect_ctrl;

    localparam int W  = 16;
    localparam int CW = 4;

    logic          clk;
    logic          reset_n;
    logic          id_valid;
    logic [3:0]    id_opcode;
    logic [W-1:0]  id_pc;
    logic [W-1:0]  id_imm;
    logic          ex_valid;
    logic [3:0]    ex_opcode;
    logic [W-1:0]  ex_pc;
    logic [W-1:0]  ex_imm;
    logic          ex_br_taken;
    logic          ex_jr_req;
    logic [W-1:0]  ex_jr_target;
    logic          redir_ready;
    logic          redir_valid;
    logic [W-1:0]  redir_pc;
    logic          flush_if;
    logic          flush_id;
    logic          stall_fe;
    logic [CW-1:0] redir_cnt;

    pc_redirect_ctrl #(.WORD_SIZE(W), .CNT_WIDTH(CW)) dut (
        .clk(clk), .reset_n(reset_n),
        .id_valid(id_valid), .id_opcode(id_opcode),
        .id_pc(id_pc), .id_imm(id_imm),
        .ex_valid(ex_valid), .ex_opcode(ex_opcode),
        .ex_pc(ex_pc), .ex_imm(ex_imm),
        .ex_br_taken(ex_br_taken), .ex_jr_req(ex_jr_req),
        .ex_jr_target(ex_jr_target), .redir_ready(redir_ready),
        .redir_valid(redir_valid), .redir_pc(redir_pc),
        .flush_if(flush_if), .flush_id(flush_id),
        .stall_fe(stall_fe), .redir_cnt(redir_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    // Model: one outstanding redirect, its target, flush pulses, accept count.
    bit            m_pend;
    logic [W-1:0]  m_pc;
    bit            m_fi;
    bit            m_fd;
    int            m_accepts;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        else
            n_pass++;
    endtask

    task automatic model_reset();
        m_pend = 0; m_pc = '0; m_fi = 0; m_fd = 0; m_accepts = 0;
    endtask

    function automatic bit is_branch(logic [3:0] op);
        return op == 4'd0 || op == 4'd1 || op == 4'd2 || op == 4'd3;
    endfunction

    task automatic model_step();
        if (m_pend) begin
            m_fi = 0; m_fd = 0;
            if (redir_ready) begin
                m_pend = 0;
                m_accepts++;
            end
        end else if (ex_valid && ((is_branch(ex_opcode) && ex_br_taken) || ex_jr_req)) begin
            m_pend = 1;
            m_pc = ex_jr_req ? ex_jr_target : W'((int'(ex_pc) + int'(ex_imm)) % 65536);
            m_fi = 1; m_fd = 1;
        end else if (id_valid && (id_opcode == 4'd9 || id_opcode == 4'd10)) begin
            m_pend = 1;
            m_pc = (id_pc & 16'hF000) | (id_imm & 16'h0FFF);
            m_fi = 1; m_fd = 0;
        end else begin
            m_fi = 0; m_fd = 0;
        end
    endtask

    task automatic compare_all();
        chk("redir_valid", 32'(redir_valid), 32'(m_pend));
        chk("stall_fe", 32'(stall_fe), 32'(m_pend));
        chk("flush_if", 32'(flush_if), 32'(m_fi));
        chk("flush_id", 32'(flush_id), 32'(m_fd));
        chk("redir_cnt", 32'(redir_cnt), 32'(m_accepts % (1 << CW)));
        if (m_pend) chk("redir_pc", 32'(redir_pc), 32'(m_pc));
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic clr();
        id_valid = 0; id_opcode = 4'd4; id_pc = '0; id_imm = '0;
        ex_valid = 0; ex_opcode = 4'd4; ex_pc = '0; ex_imm = '0;
        ex_br_taken = 0; ex_jr_req = 0; ex_jr_target = '0;
    endtask

    initial begin
        reset_n = 0;
        redir_ready = 1;
        clr();
        model_reset();
        repeat (2) @(negedge clk);
        compare_all();
        chk("rst_pc", 32'(redir_pc), 32'h0);
        reset_n = 1;
        cyc();

        // Non-requesting traffic: not-taken branch, non-jump opcode in ID.
        ex_valid = 1; ex_opcode = 4'd1; ex_pc = 16'h0040; ex_imm = 16'h0003;
        id_valid = 1; id_opcode = 4'd15;
        cyc();
        chk("nt_valid", 32'(redir_valid), 32'h0);
        clr();

        // Taken BEQ.
        ex_valid = 1; ex_opcode = 4'd1; ex_pc = 16'h0010; ex_imm = 16'h0005;
        ex_br_taken = 1;
        cyc();
        chk("beq_pc", 32'(redir_pc), 32'h0015);
        chk("beq_fid", 32'(flush_id), 32'h1);
        clr();
        cyc();
        chk("beq_cnt", 32'(redir_cnt), 32'h1);
        chk("beq_fif_off", 32'(flush_if), 32'h0);

        // JMP from ID.
        id_valid = 1; id_opcode = 4'd9; id_pc = 16'h3456; id_imm = 16'h0ABC;
        cyc();
        chk("jmp_pc", 32'(redir_pc), 32'h3ABC);
        chk("jmp_fif", 32'(flush_if), 32'h1);
        chk("jmp_fid", 32'(flush_id), 32'h0);
        clr();
        cyc();

        // JAL in ID loses to BNE in EX; target wraps.
        id_valid = 1; id_opcode = 4'd10; id_pc = 16'h7000; id_imm = 16'h0123;
        ex_valid = 1; ex_opcode = 4'd0; ex_pc = 16'hFFFE; ex_imm = 16'h0003;
        ex_br_taken = 1;
        cyc();
        chk("pri_pc", 32'(redir_pc), 32'h0001);
        chk("pri_fid", 32'(flush_id), 32'h1);
        clr();
        cyc();

        // JPR under backpressure; younger requests arrive and are ignored.
        redir_ready = 0;
        ex_valid = 1; ex_opcode = 4'd15; ex_jr_req = 1; ex_jr_target = 16'h1234;
        cyc();
        clr();
        id_valid = 1; id_opcode = 4'd9; id_pc = 16'h5000; id_imm = 16'h0777;
        ex_valid = 1; ex_opcode = 4'd1; ex_pc = 16'h0100; ex_imm = 16'h0001;
        ex_br_taken = 1;
        repeat (3) begin
            cyc();
            chk("bp_pc", 32'(redir_pc), 32'h1234);
            chk("bp_stall", 32'(stall_fe), 32'h1);
            chk("bp_fif", 32'(flush_if), 32'h0);
        end
        redir_ready = 1;
        cyc();
        chk("bp_cnt", 32'(redir_cnt), 32'h4);
        chk("bp_idle", 32'(redir_valid), 32'h0);
        clr();
        cyc();
        chk("bp_cnt_once", 32'(redir_cnt), 32'h4);

        // Async reset in the middle of a pending redirect.
        redir_ready = 0;
        id_valid = 1; id_opcode = 4'd10; id_pc = 16'h2000; id_imm = 16'h0055;
        cyc();
        clr();
        #2 reset_n = 0;
        #1;
        model_reset();
        chk("arst_valid", 32'(redir_valid), 32'h0);
        chk("arst_stall", 32'(stall_fe), 32'h0);
        chk("arst_fif", 32'(flush_if), 32'h0);
        chk("arst_pc", 32'(redir_pc), 32'h0);
        chk("arst_cnt", 32'(redir_cnt), 32'h0);
        @(negedge clk);
        reset_n = 1;
        redir_ready = 1;
        cyc();

        // Held JMP with ready: back-to-back redirects every two cycles.
        id_valid = 1; id_opcode = 4'd9; id_pc = 16'hA000; id_imm = 16'h0F0F;
        repeat (30) cyc();
        chk("wrap_pre", 32'(redir_cnt), 32'hF);
        cyc();
        clr();
        cyc();
        chk("wrap_zero", 32'(redir_cnt), 32'h0);
        cyc();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
